// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  // Width of one FIFO word and of each requester's data lane.
  localparam int FIFO_WIDTH = 140;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    SETTLE  = 2'd2,
    BLOCKED = 2'd3
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin selector: the first set request at or after
// ptr (wrapping) wins, and the grant is returned one-hot.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;
  logic [2*NUM_REQ-1:0] gnt_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot_req = req_dbl[NUM_REQ-1:0];
    rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    gnt     = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin write arbiter in front of an async FIFO.
// Grants up to DEPTH writes per burst, then goes quiet for SETTLE_CYC
// cycles so the synchronized fifo_full flag can catch up before the
// next burst. Define FIFO_ARB_STATS_EN to add wr_count / stall_count.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_enable,
  output logic [FIFO_WIDTH-1:0]         data_to_fifo,
  output logic [grant_w(NUM_REQ)-1:0]   grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   wr_count,
  output logic [15:0]                   stall_count
`endif
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  arb_state_t           state, state_next;
  logic [CW-1:0]        credit, credit_next;
  logic [SW-1:0]        settle_cnt, settle_cnt_next;
  logic [GW-1:0]        rr_ptr;
  logic                 eligible;
  logic                 any_valid;
  logic                 accept;
  logic [NUM_REQ-1:0]   gnt;
  logic [GW-1:0]        sel_idx;
  logic [FIFO_WIDTH-1:0] sel_data;
  logic [FIFO_WIDTH-1:0] masked [NUM_REQ];

  assign any_valid = |req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (GW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Only the granted lane survives the mask, so other lanes' data is ignored.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign masked[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH] & {FIFO_WIDTH{gnt[gi]}};
  end

  // OR-reduce the masked lanes and encode the one-hot grant to an index.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | masked[i];
      if (gnt[i]) sel_idx = sel_idx | GW'(i);
    end
  end

  // FSM state, credit and settle counter registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      credit     <= CW'(DEPTH);
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      credit     <= credit_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state logic plus the combinational accept strobe; a full FIFO
  // drops req_ready in the very cycle it is seen.
  always_comb begin
    state_next      = state;
    credit_next     = credit;
    settle_cnt_next = settle_cnt;
    eligible        = ((state == IDLE) || (state == BURST)) && !fifo_full && (credit != '0);
    req_ready       = eligible ? gnt : '0;
    accept          = eligible && any_valid;
    if (accept) credit_next = credit - CW'(1);

    case (state)
      IDLE: begin
        if (fifo_full) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end else if (accept) begin
          state_next      = (credit == CW'(1)) ? SETTLE : BURST;
          settle_cnt_next = '0;
        end
      end
      BURST: begin
        if (fifo_full || !any_valid || (credit == '0) || (accept && (credit == CW'(1)))) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          if (fifo_full) begin
            state_next = BLOCKED;
          end else begin
            state_next  = IDLE;
            credit_next = CW'(DEPTH);
          end
        end else begin
          settle_cnt_next = settle_cnt + SW'(1);
        end
      end
      BLOCKED: begin
        if (!fifo_full) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered write port and round-robin pointer; reset discards any
  // transfer accepted in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      fifo_w_enable <= 1'b0;
      data_to_fifo  <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
    end else begin
      fifo_w_enable <= accept;
      if (accept) begin
        data_to_fifo <= sel_data;
        grant_id     <= sel_idx;
        rr_ptr       <= (sel_idx == GW'(NUM_REQ - 1)) ? '0 : sel_idx + GW'(1);
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating counters of FIFO writes and of stalled-request cycles.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_w_enable && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (((state == SETTLE) || (state == BLOCKED)) && any_valid && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DEPTH, default 2, FIFO entries granted per burst.
REQ-003 SHALL have parameter SETTLE_CYC, default 4, quiet cycles after a burst, at least the fifo_full synchronizer latency plus 1.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester data-valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*140, requester i data in bits [140*i+139:140*i].
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot-or-zero accept strobe.
REQ-009 SHALL have port fifo_full, input, 1, async FIFO full flag, already synchronized to clk_in.
REQ-010 SHALL have port fifo_w_enable, output, 1, registered FIFO write strobe.
REQ-011 SHALL have port data_to_fifo, output, 140, registered FIFO write data.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ), registered index of the last accepted requester.

Function
REQ-013 SHALL implement FSM states IDLE, BURST, SETTLE and BLOCKED.
REQ-014 SHALL keep credit counter credit, range 0..DEPTH, which is DEPTH in IDLE.
REQ-015 SHALL in IDLE or BURST, with credit>0 and fifo_full=0, assert req_ready for exactly one valid requester, chosen round-robin starting after the last granted index.
REQ-016 SHALL accept a transfer when req_valid[i]&req_ready[i]; the next cycle fifo_w_enable=1, data_to_fifo=req_data[i], grant_id=i, credit decrements.
REQ-017 SHALL go IDLE->BURST on the first transfer; BURST->SETTLE when credit reaches 0 or no request is valid.
REQ-018 SHALL in SETTLE assert no req_ready and count SETTLE_CYC cycles; at the end go to IDLE with credit=DEPTH if fifo_full=0, else to BLOCKED.
REQ-019 SHALL in BLOCKED hold req_ready=0 until fifo_full=0, then re-enter SETTLE with the counter cleared.
REQ-020 SHALL drop req_ready the same cycle fifo_full=1 is sampled in IDLE or BURST and go to SETTLE.
REQ-021 SHALL wrap the round-robin pointer from NUM_REQ-1 to 0; with a single requester valid, it SHALL be granted every eligible cycle.
REQ-022 SHALL drive fifo_w_enable=0 in every cycle not following an accept; data_to_fifo SHALL hold its last value.
REQ-023 SHALL ignore req_data of non-granted requesters and never issue two writes for one accept.

Reset
REQ-024 SHALL on rst=1 at a clock edge set state=IDLE, credit=DEPTH, round-robin pointer=0, fifo_w_enable=0, data_to_fifo=0, grant_id=0 and req_ready=0.
REQ-025 SHALL drop a transfer accepted in the same cycle as reset; no write issues after it.

Configuration
REQ-026 SHALL, when macro FIFO_ARB_STATS_EN is defined, add output wr_count (16 bits), a saturating count of fifo_w_enable pulses.
REQ-027 SHALL, when FIFO_ARB_STATS_EN is defined, add output stall_count (16 bits), a saturating count of SETTLE/BLOCKED cycles with any req_valid high; both counters clear on rst.
REQ-028 SHALL, when FIFO_ARB_STATS_EN is undefined, omit both ports and counters, with all other behaviour identical.

Structure
REQ-029 SHALL place FIFO_WIDTH=140, the state enum arb_state_t and the grant index width helper in package fifo_arb_pkg.
REQ-030 SHALL put round-robin selection (request vector plus pointer in, one-hot grant out, combinational) in sub-module rr_arbiter.

Verification
REQ-031 SHALL cover: reset, then req_valid=4'b0001, data 0xA5, fifo_full=0 -> one cycle later fifo_w_enable=1, data_to_fifo=0xA5, grant_id=0; second write next cycle; then 4 SETTLE cycles with req_ready=0.
REQ-032 SHALL cover: req_valid=4'b1111 held, fifo_full=0 -> grant order 0,1 | settle | 2,3 | settle | 0,1.
REQ-033 SHALL cover: fifo_full=1 raised at the end of SETTLE and held 10 cycles -> BLOCKED, no writes; after fifo_full=0, 4 settle cycles, then writes resume.
REQ-034 SHALL cover: fifo_full=1 sampled in BURST with credit=1 -> req_ready=0 the same cycle, no write the next cycle.
REQ-035 SHALL cover: rst=1 in the cycle of an accept -> fifo_w_enable=0 the next cycle and grant_id=0.
REQ-036 SHALL cover, with FIFO_ARB_STATS_EN defined: 70000 writes -> wr_count=16'hFFFF; stall_count increments only during settle cycles with a request pending.
